// File: rtl/rv32i_mem_arb_pkg.sv
// rv32i_mem_arb_pkg: shared FSM state encodings and grant identifiers for the memory arbiter.
package rv32i_mem_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;
  localparam logic ARB_GNT_I = 1'b0;
  localparam logic ARB_GNT_D = 1'b1;
endpackage

// File: rtl/rv32i_mem_arb_slot.sv
// mem_req_slot: one port's request slot (pend flag, captured addr/wdata/wmask/kind, read-data register).
//  i_strb/i_kind/i_addr/i_wdata/i_wmask : incoming request (kind 1 = store)
//  i_done/i_mrdata                      : completion of this slot's transaction and downstream read data
//  o_req/o_busy                         : request present (pending or new) / port busy
//  o_kind/o_addr/o_wdata/o_wmask        : effective request (captured if pending, else live inputs)
//  o_rdata                              : read data, bypassed from downstream in the completion cycle
module mem_req_slot
  import rv32i_mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_strb,
  input  logic            i_kind,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_wmask,
  input  logic            i_done,
  input  logic [DW-1:0]   i_mrdata,
  output logic            o_req,
  output logic            o_busy,
  output logic            o_kind,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_wdata,
  output logic [DW/8-1:0] o_wmask,
  output logic [DW-1:0]   o_rdata
);
  logic            r_pend;
  logic            r_kind;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wmask;
  logic [DW-1:0]   r_rdata;
  logic            w_rd_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_kind  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
    end else if (!r_pend && i_strb) begin
      r_pend  <= 1'b1;
      r_kind  <= i_kind;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_wmask <= i_wmask;
    end else if (i_done) begin
      r_pend <= 1'b0;
      if (!r_kind) r_rdata <= i_mrdata;
    end
  end
  assign w_rd_done = i_done & ~r_kind;
  assign o_req     = r_pend | i_strb;
  assign o_busy    = (r_pend & ~i_done) | (i_strb & ~r_pend);
  assign o_kind    = r_pend ? r_kind  : i_kind;
  assign o_addr    = r_pend ? r_addr  : i_addr;
  assign o_wdata   = r_pend ? r_wdata : i_wdata;
  assign o_wmask   = r_pend ? r_wmask : i_wmask;
  // Read data becomes visible in the completion cycle, together with busy dropping.
  assign o_rdata   = w_rd_done ? i_mrdata : r_rdata;
endmodule

// File: rtl/rv32i_mem_arb.sv
// rv32i_mem_arb: shares one downstream memory port between the rv32i fetch (i_*) and data (d_*) ports.
//  Upstream: strobe + busy handshakes per port, rdata held until that port's next completed read.
//  Downstream: registered m_addr/m_wdata/m_wmask with 1-cycle m_rstrb/m_wstrb, completion on m_rbusy/m_wbusy low.
//  MEM_ARB_RR_EN: round-robin on ties (last grant resets to I); otherwise D has fixed priority over I.
module rv32i_mem_arb
  import rv32i_mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_rstrb,
  output logic [DW-1:0]   i_rdata,
  output logic            i_rbusy,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  input  logic            d_wstrb,
  input  logic            d_rstrb,
  output logic [DW-1:0]   d_rdata,
  output logic            d_rbusy,
  output logic            d_wbusy,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wmask,
  output logic            m_rstrb,
  output logic            m_wstrb,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_rbusy,
  input  logic            m_wbusy
);
  arb_state_t      r_state;
  arb_state_t      w_next;
  logic            r_gnt;
  logic            r_kind;
  logic            w_gnt;
  logic            w_any;
  logic            w_done;
  logic            w_done_i;
  logic            w_done_d;
  logic            w_req_i;
  logic            w_req_d;
  logic            w_busy_i;
  logic            w_busy_d;
  logic            w_kind_i;
  logic            w_kind_d;
  logic [AW-1:0]   w_addr_i;
  logic [AW-1:0]   w_addr_d;
  logic [DW-1:0]   w_wdata_i;
  logic [DW-1:0]   w_wdata_d;
  logic [DW/8-1:0] w_wmask_i;
  logic [DW/8-1:0] w_wmask_d;
  mem_req_slot #(.AW(AW), .DW(DW)) u_slot_i (
    .clk(clk), .rst_n(rst_n), .i_strb(i_rstrb), .i_kind(1'b0), .i_addr(i_addr),
    .i_wdata('0), .i_wmask('0), .i_done(w_done_i), .i_mrdata(m_rdata),
    .o_req(w_req_i), .o_busy(w_busy_i), .o_kind(w_kind_i), .o_addr(w_addr_i),
    .o_wdata(w_wdata_i), .o_wmask(w_wmask_i), .o_rdata(i_rdata)
  );
  // A simultaneous store and load collapses to a store; the load is dropped.
  mem_req_slot #(.AW(AW), .DW(DW)) u_slot_d (
    .clk(clk), .rst_n(rst_n), .i_strb(d_wstrb | d_rstrb), .i_kind(d_wstrb), .i_addr(d_addr),
    .i_wdata(d_wdata), .i_wmask(d_wmask), .i_done(w_done_d), .i_mrdata(m_rdata),
    .o_req(w_req_d), .o_busy(w_busy_d), .o_kind(w_kind_d), .o_addr(w_addr_d),
    .o_wdata(w_wdata_d), .o_wmask(w_wmask_d), .o_rdata(d_rdata)
  );
  assign w_any    = w_req_i | w_req_d;
  assign w_done   = (r_state == ARB_WAIT) & (r_kind ? ~m_wbusy : ~m_rbusy);
  assign w_done_i = w_done & (r_gnt == ARB_GNT_I);
  assign w_done_d = w_done & (r_gnt == ARB_GNT_D);
  assign i_rbusy  = w_busy_i;
  assign d_rbusy  = w_busy_d & ~w_kind_d;
  assign d_wbusy  = w_busy_d & w_kind_d;
  assign m_rstrb  = (r_state == ARB_ISSUE) & ~r_kind;
  assign m_wstrb  = (r_state == ARB_ISSUE) & r_kind;
`ifdef MEM_ARB_RR_EN
  logic r_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= ARB_GNT_I;
    else if (r_state == ARB_IDLE && w_any) r_last <= w_gnt;
  end
  assign w_gnt = (w_req_i & w_req_d) ? ~r_last : w_req_d;
`else
  assign w_gnt = w_req_d;
`endif
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ARB_IDLE)  ? (w_any ? ARB_ISSUE : ARB_IDLE) :
             (r_state == ARB_ISSUE) ? ARB_WAIT :
             (w_done ? ARB_IDLE : ARB_WAIT);
  end
  // The grant is taken in IDLE from pending or same-cycle strobes, so a fresh request issues the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_gnt   <= ARB_GNT_I;
      r_kind  <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wmask <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ARB_IDLE && w_any) begin
        r_gnt   <= w_gnt;
        r_kind  <= w_gnt ? w_kind_d  : w_kind_i;
        m_addr  <= w_gnt ? w_addr_d  : w_addr_i;
        m_wdata <= w_gnt ? w_wdata_d : w_wdata_i;
        m_wmask <= w_gnt ? w_wmask_d : w_wmask_i;
      end
    end
  end
endmodule
